// File: rtl/sam_regfile_paged.sv
// SAM control-register block with toggle-bit map at FFC0-FFDF, compatibility bulk writes,
// and a key-protected bank of byte-addressable page registers. All state moves on the falling edge.
module sam_regfile_paged #(
    parameter int          NUM_PAGES  = 4,
    parameter int          PAGE_WIDTH = 6,
    parameter logic [15:0] PAGE_BASE  = 16'hFFA0,
    parameter logic [7:0]  KEY1       = 8'hA5,
    parameter logic [7:0]  KEY2       = 8'h5A
) (
    input  logic                             clk,
    input  logic                             RESET,
    input  logic [15:0]                      A,
    input  logic [7:0]                       D,
    input  logic                             RnW,
    input  logic                             VMA,
    output logic [7:0]                       DOUT,
    output logic                             DOE,
    output logic [3:0]                       V,
    output logic [7:0]                       F,
    output logic [1:0]                       R,
    output logic                             P,
    output logic                             C,
    output logic                             TY,
    output logic [1:0]                       M,
    output logic                             PAGE_EN,
    output logic [NUM_PAGES*PAGE_WIDTH-1:0]  PAGES
);

    localparam int          IDX_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam logic [15:0] NUM_PAGES_W = 16'(NUM_PAGES);

    typedef enum logic [1:0] {
        LOCKED = 2'b00,
        ARMED  = 2'b01,
        OPEN   = 2'b10
    } unlock_t;

    unlock_t                 state_q, state_d;
    logic [3:0]              v_q, v_d;
    logic [7:0]              f_q, f_d;
    logic [1:0]              r_q, r_d;
    logic                    page_en_q, page_en_d;
    logic                    doe_q, doe_d;
    logic [7:0]              dout_q, dout_d;
    logic [PAGE_WIDTH-1:0]   pages_q [NUM_PAGES];
    logic [PAGE_WIDTH-1:0]   pages_d [NUM_PAGES];

    // P, C and TY survive RESET; their only defined value is the power-up one.
    logic p_q  = 1'b0;
    logic c_q  = 1'b0;
    logic ty_q = 1'b0;
    logic p_d, c_d, ty_d;

    logic              toggle_hit, bulk_wr, key_wr, en_hit, page_hit;
    logic [3:0]        tog_idx;
    logic [15:0]       page_off;
    logic [IDX_W-1:0]  page_idx;

    always_comb begin
        toggle_hit = VMA && (A[15:5] == 11'h7FE);
        tog_idx    = A[4:1];
        bulk_wr    = toggle_hit && c_q && !RnW;
        key_wr     = VMA && !RnW && (A == 16'hFFDC);
        en_hit     = VMA && (A == 16'hFFDD);
        page_off   = A - PAGE_BASE;
        page_hit   = VMA && (page_off < NUM_PAGES_W);
        page_idx   = page_off[IDX_W-1:0];
    end

    // NOTE: every next-state signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        v_d       = v_q;
        f_d       = f_q;
        r_d       = r_q;
        p_d       = p_q;
        c_d       = c_q;
        ty_d      = ty_q;
        state_d   = state_q;
        page_en_d = page_en_q;
        pages_d   = pages_q;
        doe_d     = 1'b0;
        dout_d    = 8'h00;

        if (toggle_hit) begin
            if (bulk_wr && tog_idx == 4'd0) begin
                v_d = D[3:0];
            end else if (bulk_wr && tog_idx == 4'd3) begin
                f_d = D;
            end else begin
                case (tog_idx)
                    4'd0, 4'd1, 4'd2:                      v_d[tog_idx[1:0]] = A[0];
                    4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: f_d[3'(tog_idx - 4'd3)] = A[0];
                    4'd10:                                 p_d = A[0];
                    4'd11, 4'd12:                          r_d[~tog_idx[0]] = A[0];
                    4'd13:                                 c_d = A[0];
                    4'd15:                                 ty_d = A[0];
                    default: ;
                endcase
            end
        end

        if (key_wr) begin
            case (state_q)
                LOCKED:  state_d = (D == KEY1) ? ARMED : LOCKED;
                ARMED:   state_d = (D == KEY2) ? OPEN : LOCKED;
                OPEN:    state_d = (D == 8'h00) ? LOCKED : OPEN;
                default: state_d = LOCKED;
            endcase
        end

        if (en_hit && state_q == OPEN) begin
            page_en_d = 1'b1;
        end
        if (state_q == OPEN && state_d != OPEN) begin
            page_en_d = 1'b0;
        end

        if (page_hit) begin
            if (RnW) begin
                doe_d                    = 1'b1;
                dout_d[PAGE_WIDTH-1:0]   = pages_q[page_idx];
            end else if (state_q == OPEN) begin
                pages_d[page_idx] = D[PAGE_WIDTH-1:0];
            end
        end
    end

    // NOTE: the page bank is a handful of flops, not a RAM, so clearing it on reset is cheap and required.
    always_ff @(negedge clk) begin
        if (!RESET) begin
            state_q   <= LOCKED;
            v_q       <= 4'h0;
            f_q       <= 8'h00;
            r_q       <= 2'b00;
            page_en_q <= 1'b0;
            doe_q     <= 1'b0;
            dout_q    <= 8'h00;
            for (int n = 0; n < NUM_PAGES; n++) begin
                pages_q[n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            f_q       <= f_d;
            r_q       <= r_d;
            page_en_q <= page_en_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
            pages_q   <= pages_d;
        end
    end

    // Reset still blocks any access to these bits, it just does not clear them.
    always_ff @(negedge clk) begin
        if (RESET) begin
            p_q  <= p_d;
            c_q  <= c_d;
            ty_q <= ty_d;
        end
    end

    assign V       = v_q;
    assign F       = f_q;
    assign R       = r_q;
    assign P       = p_q;
    assign C       = c_q;
    assign TY      = ty_q;
    assign M       = 2'b11;
    assign PAGE_EN = page_en_q;
    assign DOE     = doe_q;
    assign DOUT    = dout_q;

    for (genvar n = 0; n < NUM_PAGES; n++) begin : g_pages
        assign PAGES[n*PAGE_WIDTH +: PAGE_WIDTH] = pages_q[n];
    end

endmodule

// File: tb/tb_sam_regfile_paged.sv
// Directed bench for sam_regfile_paged: toggle map, bulk writes, unlock FSM, page bank and reset.
module tb_sam_regfile_paged;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D = 8'h00;
    logic        RnW = 1'b1;
    logic        VMA = 1'b0;
    logic [7:0]  DOUT;
    logic        DOE;
    logic [3:0]  V;
    logic [7:0]  F;
    logic [1:0]  R;
    logic        P, C, TY;
    logic [1:0]  M;
    logic        PAGE_EN;
    logic [23:0] PAGES;

    int n_checks = 0;
    int n_fail   = 0;

    sam_regfile_paged dut (
        .clk(clk), .RESET(RESET), .A(A), .D(D), .RnW(RnW), .VMA(VMA),
        .DOUT(DOUT), .DOE(DOE), .V(V), .F(F), .R(R), .P(P), .C(C), .TY(TY),
        .M(M), .PAGE_EN(PAGE_EN), .PAGES(PAGES)
    );

    always #5 clk = ~clk;

    // One bus cycle: drive, let the falling edge sample it, then look 1 ns later.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rnw, input logic vma);
        A = a; D = d; RnW = rnw; VMA = vma;
        @(negedge clk);
        #1;
        VMA = 1'b0; RnW = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, d, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [15:0] a);
        bus(a, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_checks++; if (C !== 1'b0 || P !== 1'b0 || TY !== 1'b0) begin n_fail++; $display("FAIL powerup_cpty: got C=%b P=%b TY=%b, want 0 0 0", C, P, TY); end
        RESET = 1'b0;
        bus(16'h0000, 8'h00, 1'b1, 1'b0);
        RESET = 1'b1;
        n_checks++; if (V !== 4'h0 || F !== 8'h00 || R !== 2'b00) begin n_fail++; $display("FAIL reset_vfr: got V=%h F=%h R=%h, want 0 00 0", V, F, R); end
        n_checks++; if (PAGES !== 24'h0 || PAGE_EN !== 1'b0) begin n_fail++; $display("FAIL reset_pages: got PAGES=%h PAGE_EN=%b, want 0 0", PAGES, PAGE_EN); end
        n_checks++; if (DOE !== 1'b0 || DOUT !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got DOE=%b DOUT=%h, want 0 00", DOE, DOUT); end
        n_checks++; if (M !== 2'b11) begin n_fail++; $display("FAIL m_const: got %b, want 11", M); end
    endtask

    task automatic test_toggle;
        rd(16'hFFC7);
        rd(16'hFFC9);
        wr(16'hFFC6, 8'hFF);
        n_checks++; if (F !== 8'h02) begin n_fail++; $display("FAIL f_toggle: got %h, want 02", F); end
        wr(16'hFFC3, 8'h00);
        rd(16'hFFD7);
        rd(16'hFFD5);
        rd(16'hFFDF);
        n_checks++; if (V !== 4'h2 || R !== 2'b01 || P !== 1'b1 || TY !== 1'b1) begin n_fail++; $display("FAIL misc_toggle: got V=%h R=%b P=%b TY=%b, want 2 01 1 1", V, R, P, TY); end
        rd(16'hFFDB);
        n_checks++; if (C !== 1'b1) begin n_fail++; $display("FAIL c_set: got %b, want 1", C); end
    endtask

    task automatic test_bulk;
        wr(16'hFFC6, 8'hC3);
        n_checks++; if (F !== 8'hC3 || F[7] !== 1'b1) begin n_fail++; $display("FAIL f_bulk: got %h, want c3", F); end
        wr(16'hFFC0, 8'h0F);
        n_checks++; if (V !== 4'hF) begin n_fail++; $display("FAIL v_bulk: got %h, want f", V); end
        rd(16'hFFC0);
        n_checks++; if (V !== 4'hE) begin n_fail++; $display("FAIL v_read_toggle_in_c: got %h, want e", V); end
    endtask

    task automatic test_unlock;
        wr(16'hFFDC, 8'hA5);
        wr(16'hFFDC, 8'h5A);
        n_checks++; if (PAGE_EN !== 1'b0) begin n_fail++; $display("FAIL en_before_ffdd: got %b, want 0", PAGE_EN); end
        rd(16'hFFDD);
        n_checks++; if (PAGE_EN !== 1'b1 || DOE !== 1'b0) begin n_fail++; $display("FAIL en_set: got PAGE_EN=%b DOE=%b, want 1 0", PAGE_EN, DOE); end
        wr(16'hFFA2, 8'hFF);
        n_checks++; if (PAGES[17:12] !== 6'h3F) begin n_fail++; $display("FAIL page2_write: got %h, want 3f", PAGES[17:12]); end
        rd(16'hFFA2);
        n_checks++; if (DOE !== 1'b1 || DOUT !== 8'h3F) begin n_fail++; $display("FAIL page2_read: got DOE=%b DOUT=%h, want 1 3f", DOE, DOUT); end
        bus(16'hFFA2, 8'h00, 1'b1, 1'b0);
        n_checks++; if (DOE !== 1'b0) begin n_fail++; $display("FAIL doe_one_cycle: got %b, want 0", DOE); end
        wr(16'hFFA0, 8'h11);
        wr(16'hFFA3, 8'hEA);
        wr(16'hFFDC, 8'h77);
        wr(16'hFFA1, 8'h05);
        n_checks++; if (PAGES !== {6'h2A, 6'h3F, 6'h05, 6'h11} || PAGE_EN !== 1'b1) begin n_fail++; $display("FAIL pages_open: got %h en=%b, want %h 1", PAGES, PAGE_EN, {6'h2A, 6'h3F, 6'h05, 6'h11}); end
        wr(16'hFFDC, 8'h00);
        n_checks++; if (PAGE_EN !== 1'b0) begin n_fail++; $display("FAIL relock_en: got %b, want 0", PAGE_EN); end
    endtask

    task automatic test_bad_key;
        wr(16'hFFDC, 8'hA5);
        wr(16'hFFDC, 8'hA5);
        wr(16'hFFDC, 8'h5A);
        rd(16'hFFDD);
        n_checks++; if (PAGE_EN !== 1'b0) begin n_fail++; $display("FAIL bad_key_en: got %b, want 0", PAGE_EN); end
        wr(16'hFFA0, 8'h22);
        n_checks++; if (PAGES !== {6'h2A, 6'h3F, 6'h05, 6'h11}) begin n_fail++; $display("FAIL locked_write: got %h, want %h", PAGES, {6'h2A, 6'h3F, 6'h05, 6'h11}); end
        rd(16'hFFA0);
        n_checks++; if (DOE !== 1'b1 || DOUT !== 8'h11) begin n_fail++; $display("FAIL locked_read: got DOE=%b DOUT=%h, want 1 11", DOE, DOUT); end
    endtask

    task automatic test_reset_mid;
        wr(16'hFFDC, 8'hA5);
        wr(16'hFFDC, 8'h5A);
        wr(16'hFFDD, 8'h00);
        wr(16'hFFDC, 8'hA5);
        n_checks++; if (PAGE_EN !== 1'b1) begin n_fail++; $display("FAIL reopen_en: got %b, want 1", PAGE_EN); end
        RESET = 1'b0;
        rd(16'hFFA3);
        RESET = 1'b1;
        n_checks++; if (PAGE_EN !== 1'b0 || PAGES !== 24'h0 || DOE !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got en=%b PAGES=%h DOE=%b, want 0 0 0", PAGE_EN, PAGES, DOE); end
        n_checks++; if (C !== 1'b1 || P !== 1'b1 || TY !== 1'b1 || V !== 4'h0 || F !== 8'h00 || R !== 2'b00) begin n_fail++; $display("FAIL mid_reset_regs: got C=%b P=%b TY=%b V=%h F=%h R=%b, want 1 1 1 0 00 00", C, P, TY, V, F, R); end
        wr(16'hFFDC, 8'h5A);
        rd(16'hFFDD);
        wr(16'hFFA1, 8'h03);
        n_checks++; if (PAGE_EN !== 1'b0 || PAGES !== 24'h0) begin n_fail++; $display("FAIL fsm_locked_after_reset: got en=%b PAGES=%h, want 0 0", PAGE_EN, PAGES); end
    endtask

    task automatic test_back_to_back;
        rd(16'hFFA4);
        n_checks++; if (DOE !== 1'b0 || DOUT !== 8'h00) begin n_fail++; $display("FAIL out_of_range: got DOE=%b DOUT=%h, want 0 00", DOE, DOUT); end
        rd(16'hFFA3);
        n_checks++; if (DOE !== 1'b1 || DOUT !== 8'h00) begin n_fail++; $display("FAIL last_page_read: got DOE=%b DOUT=%h, want 1 00", DOE, DOUT); end
        rd(16'hFFA4);
        n_checks++; if (DOE !== 1'b0) begin n_fail++; $display("FAIL b2b_doe_drop: got %b, want 0", DOE); end
        bus(16'hFFC5, 8'h00, 1'b1, 1'b0);
        n_checks++; if (V !== 4'h0) begin n_fail++; $display("FAIL vma0_ignored: got %h, want 0", V); end
        rd(16'hFFC5);
        n_checks++; if (V !== 4'h4) begin n_fail++; $display("FAIL v2_toggle: got %h, want 4", V); end
        wr(16'hFFC7, 8'h80);
        n_checks++; if (F !== 8'h80) begin n_fail++; $display("FAIL f_bulk_odd: got %h, want 80", F); end
        n_checks++; if (M !== 2'b11) begin n_fail++; $display("FAIL m_const_end: got %b, want 11", M); end
    endtask

    initial begin
        test_reset;
        test_toggle;
        test_bulk;
        test_unlock;
        test_bad_key;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sam_regfile_paged.md
# sam_regfile_paged

Parametrised successor to the SAM control-register block. It keeps the toggle-bit register map at FFC0–FFDF and the compatibility-mode bulk writes for V and F. It adds a key-protected unlock sequence, a page-enable bit, and a bank of byte-wide page registers with read-back. It sits between the CPU address/data bus and the SAM video/refresh/mapping logic, and drives the paging inputs of the address multiplexer.

## Interface
Parameters:
- NUM_PAGES, 4: number of page registers (1–16).
- PAGE_WIDTH, 6: width of each page register (1–8).
- PAGE_BASE, 16'hFFA0: address of page register 0; register n is at PAGE_BASE+n.
- KEY1, 8'hA5: first unlock byte.
- KEY2, 8'h5A: second unlock byte.

Ports:
- clk  in  1  system clock; all state changes on the falling edge.
- RESET  in  1  synchronous, active-low reset, sampled on the falling edge of clk.
- A  in  16  CPU address.
- D  in  8  CPU write data.
- RnW  in  1  1 = read, 0 = write.
- VMA  in  1  valid access; exactly one cycle with VMA=1 per bus access.
- DOUT  out  8  read-back data, zero-extended page register.
- DOE  out  1  DOUT valid, drive the data bus.
- V  out  4  video mode.
- F  out  8  video base address / 512.
- R  out  2  MPU rate.
- P  out  1  page bit.
- C  out  1  compatibility/bulk-write enable.
- TY  out  1  map type.
- M  out  2  memory size, constant 2'b11.
- PAGE_EN  out  1  paging enabled.
- PAGES  out  NUM_PAGES*PAGE_WIDTH  page n is at [n*PAGE_WIDTH +: PAGE_WIDTH].

## Operation
- Nothing changes unless VMA=1. The RESET=0 branch has priority over everything.
- Toggle map: for an access to FFC0–FFDF, A[0] is the value written to the selected bit, for both reads and writes.
  - FFC0/1–FFC4/5: V[0..2].
  - FFC6/7–FFD2/3: F[0..6].
  - FFD4/5: P.
  - FFD6/7–FFD8/9: R[0..1].
  - FFDA/B: C.
  - FFDE/F: TY.
- Bulk write (C=1 and RnW=0):
  - FFC0 or FFC1: V ← D[3:0]. This replaces the V[0] toggle.
  - FFC6 or FFC7: F ← D[7:0]. This replaces the F[0] toggle.
  - F[7] is reachable only by bulk write.
- Unlock FSM. States LOCKED (00), ARMED (01), OPEN (10). Only writes to FFDC advance it; reads of FFDC and all other addresses leave it unchanged.
  - LOCKED: D=KEY1 → ARMED; any other data → stay LOCKED.
  - ARMED: D=KEY2 → OPEN; any other data → LOCKED.
  - OPEN: D=8'h00 → LOCKED and PAGE_EN ← 0; any other data → stay OPEN.
- PAGE_EN control:
  - In OPEN, any access to FFDD sets PAGE_EN ← 1.
  - In LOCKED or ARMED, accesses to FFDD are ignored.
  - Leaving OPEN always clears PAGE_EN.
- Page bank, for an access to PAGE_BASE+n with n<NUM_PAGES:
  - Write in OPEN: page[n] ← D[PAGE_WIDTH-1:0].
  - Read in any state: DOUT ← {0, page[n]}, DOE ← 1.
  - Write outside OPEN: ignored.
  - n≥NUM_PAGES: no effect and DOE stays 0.
- DOE is 0 on every other sampled edge, including VMA=0.

## Timing
- All outputs are registered and update on the falling edge that samples the access. Latency is zero edges: the value is visible in the half-cycle after that edge.
- DOE/DOUT stay valid for exactly one clk period, until the next falling edge.
- Unlock takes two qualifying writes. PAGE_EN rises at the earliest on the third access (FFDD).
- A KEY1 write while in ARMED returns to LOCKED; it does not re-arm.
- Reset (RESET=0 at a falling edge, including mid-sequence) sets:
  - V=0, F=0, R=0.
  - All pages=0, PAGE_EN=0, FSM=LOCKED.
  - DOUT=0, DOE=0.
- P, C and TY are not reset by RESET. Their power-up value is 0.
- M=2'b11 at all times.

## Test plan
- Power-up, then RESET low for one edge → V=0, F=0, R=0, PAGES=0, PAGE_EN=0, DOE=0, M=3.
- Access FFC7, FFC9, then FFC6 with VMA=1 → F=8'h02. Set C via FFDB, then write FFC6 with D=8'hC3 → F=8'hC3 and F[7]=1.
- Write FFDC with A5, then 5A; read FFDD → PAGE_EN=1. Write FFA2 with D=8'hFF → PAGES[17:12]=6'h3F. Read FFA2 → DOE=1, DOUT=8'h3F for one cycle.
- Write FFDC with A5, A5, then 5A → FSM stays LOCKED. Access FFDD → PAGE_EN=0. Write FFA0 with 8'h11 → page0 unchanged.
- When OPEN with PAGE_EN=1: assert RESET between the two key writes of a re-unlock → LOCKED and PAGE_EN=0, with C/P/TY retained.
- Read FFA4 with NUM_PAGES=4 → DOE=0. Access FFC5 with VMA=0 → V unchanged.
